clk_step_ctrl: RTL and testbench

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

---
 rtl/clk_step_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_step_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable controller: free-run divider or debounced single-step,
// with a sticky halt state and a saturating strobe counter.
module clk_step_ctrl #(
   parameter int divisor  = 1,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        SYS_reset,
   input  logic        run_mode,
   input  logic        step_btn,
   input  logic        halt,
   output logic        cpu_en,
   output logic        CLK_led,
   output logic [31:0] cycle_count,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_STEP    = 2'b01,
      ST_HALTED  = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_e;

   localparam logic [23:0] DIV_LAST = 24'(divisor - 1);
   localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE - 1);

   logic        run_meta_q;
   logic        run_sync_q;
   logic        btn_meta_q;
   logic        btn_sync_q;
   logic [7:0]  deb_cnt_q;
   logic [7:0]  deb_cnt_d;
   logic        btn_db_q;
   logic        btn_db_d;
   logic        btn_prev_q;
   logic        step_rise_s;
   state_e      state_q;
   state_e      state_d;
   logic [23:0] div_cnt_q;
   logic [23:0] div_cnt_d;
   logic        strobe_d;
   logic        cpu_en_q;
   logic        led_q;
   logic [31:0] count_q;

   // Two-flop synchronizers for the asynchronous mode switch and pushbutton.
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         run_meta_q <= 1'b0;
         run_sync_q <= 1'b0;
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
      end else begin
         run_meta_q <= run_mode;
         run_sync_q <= run_meta_q;
         btn_meta_q <= step_btn;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Debounce next-state: any sample agreeing with btn_db restarts the count.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      btn_db_d  = btn_db_q;
      if (btn_sync_q != btn_db_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_db_d  = btn_sync_q;
            deb_cnt_d = 8'd0;
         end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
         end
      end else begin
         deb_cnt_d = 8'd0;
      end
   end

   // Debounce counter, debounced level and its one-cycle-delayed copy.
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         deb_cnt_q  <= 8'd0;
         btn_db_q   <= 1'b0;
         btn_prev_q <= 1'b0;
      end else begin
         deb_cnt_q  <= deb_cnt_d;
         btn_db_q   <= btn_db_d;
         btn_prev_q <= btn_db_q;
      end
   end

   assign step_rise_s = btn_db_q & ~btn_prev_q;

   // FSM next-state; halt outranks any strobe, and a strobe in RUN also needs run_mode still high.
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      strobe_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt) begin
               state_d   = ST_HALTED;
               div_cnt_d = 24'd0;
            end else if (!run_sync_q) begin
               state_d   = ST_STEP;
               div_cnt_d = 24'd0;
            end else if (div_cnt_q == DIV_LAST) begin
               strobe_d  = 1'b1;
               div_cnt_d = 24'd0;
            end else begin
               div_cnt_d = div_cnt_q + 24'd1;
            end
         end
         ST_STEP: begin
            div_cnt_d = 24'd0;
            if (halt) begin
               state_d = ST_HALTED;
            end else begin
               strobe_d = step_rise_s;
               if (run_sync_q) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_STEP;
               end
            end
         end
         ST_HALTED: begin
            state_d   = ST_HALTED;
            div_cnt_d = 24'd0;
         end
         default: begin
            state_d   = ST_STEP;
            div_cnt_d = 24'd0;
         end
      endcase
   end

   // FSM state, divider and registered strobe outputs.
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q   <= ST_STEP;
         div_cnt_q <= 24'd0;
         cpu_en_q  <= 1'b0;
         led_q     <= 1'b0;
         count_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         cpu_en_q  <= strobe_d;
         if (strobe_d) begin
            led_q <= ~led_q;
            if (count_q != 32'hFFFF_FFFF) begin
               count_q <= count_q + 32'd1;
            end else begin
               count_q <= count_q;
            end
         end else begin
            led_q   <= led_q;
            count_q <= count_q;
         end
      end
   end

   assign cpu_en      = cpu_en_q;
   assign CLK_led     = led_q;
   assign cycle_count = count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: two instances (divisor 4 / debounce 4, divisor 1 / debounce 2)
// on shared stimulus, each compared every cycle against a behavioural model.
module tb_clk_step_ctrl;

   localparam int DIV_A = 4;
   localparam int DEB_A = 4;
   localparam int DIV_B = 1;
   localparam int DEB_B = 2;
   localparam int HIST  = 8192;

   logic        clk = 1'b0;
   logic        SYS_reset, run_mode, step_btn, halt;
   logic        en_a, led_a, en_b, led_b;
   logic [31:0] cnt_a, cnt_b;
   logic [1:0]  st_a, st_b;

   always #5 clk = ~clk;

   clk_step_ctrl #(.divisor(DIV_A), .DEBOUNCE(DEB_A)) u_dut_a (
      .clk(clk), .SYS_reset(SYS_reset), .run_mode(run_mode), .step_btn(step_btn), .halt(halt),
      .cpu_en(en_a), .CLK_led(led_a), .cycle_count(cnt_a), .state(st_a));

   clk_step_ctrl #(.divisor(DIV_B), .DEBOUNCE(DEB_B)) u_dut_b (
      .clk(clk), .SYS_reset(SYS_reset), .run_mode(run_mode), .step_btn(step_btn), .halt(halt),
      .cpu_en(en_b), .CLK_led(led_b), .cycle_count(cnt_b), .state(st_b));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: edge index since reset, input history, per-instance mode.
   int          divs [2];
   int          debs [2];
   int          t_m;
   bit          rm_h [HIST];
   bit          sb_h [HIST];
   int          mode_m  [2];   // 0 run, 1 step, 2 halted
   int          entry_m [2];   // edge index at which RUN was entered
   bit          db_m [2], dbo_m [2], en_m [2], led_m [2];
   logic [31:0] cnt_m [2];

   task automatic model_reset();
      t_m = 0;
      for (int i = 0; i < 2; i++) begin
         mode_m[i] = 1; entry_m[i] = 0;
         db_m[i] = 1'b0; dbo_m[i] = 1'b0; en_m[i] = 1'b0; led_m[i] = 1'b0;
         cnt_m[i] = 32'd0;
      end
   endtask

   task automatic model_edge();
      bit sync_run, rise, strobe, flip, s;
      int idx;
      t_m++;
      if (t_m >= HIST) begin
         $display("FAIL model_history: edge index %0d exceeds %0d", t_m, HIST);
         $fatal(1);
      end
      rm_h[t_m] = run_mode;
      sb_h[t_m] = step_btn;
      sync_run = (t_m >= 3) ? rm_h[t_m-2] : 1'b0;
      for (int i = 0; i < 2; i++) begin
         rise   = db_m[i] && !dbo_m[i];
         strobe = 1'b0;
         if (mode_m[i] == 2) begin
            strobe = 1'b0;
         end else if (halt) begin
            mode_m[i] = 2;
         end else if (mode_m[i] == 0) begin
            strobe = sync_run && (((t_m - entry_m[i]) % divs[i]) == 0);
            if (!sync_run) mode_m[i] = 1;
         end else begin
            strobe = rise;
            if (sync_run) begin
               mode_m[i] = 0;
               entry_m[i] = t_m;
            end
         end
         // level flips once the last debs[i] synchronized samples all disagree with it
         flip = 1'b1;
         for (int k = 0; k < debs[i]; k++) begin
            idx = t_m - 2 - k;
            s = (idx >= 1) ? sb_h[idx] : 1'b0;
            if (s == db_m[i]) flip = 1'b0;
         end
         dbo_m[i] = db_m[i];
         if (flip) db_m[i] = !db_m[i];
         en_m[i] = strobe;
         if (strobe) begin
            led_m[i] = !led_m[i];
            if (cnt_m[i] != 32'hFFFF_FFFF) cnt_m[i] = cnt_m[i] + 32'd1;
         end
      end
   endtask

   task automatic check_outs();
      chk("cpu_en_a", 32'(en_a), 32'(en_m[0]));
      chk("led_a", 32'(led_a), 32'(led_m[0]));
      chk("count_a", cnt_a, cnt_m[0]);
      chk("state_a", 32'(st_a), 32'(mode_m[0]));
      chk("cpu_en_b", 32'(en_b), 32'(en_m[1]));
      chk("led_b", 32'(led_b), 32'(led_m[1]));
      chk("count_b", cnt_b, cnt_m[1]);
      chk("state_b", 32'(st_b), 32'(mode_m[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!SYS_reset) model_edge();
      #1;
      check_outs();
   endtask

   // Called at posedge+1: assert between edges, check asynchronously, release after the next edge.
   task automatic do_reset();
      #2 SYS_reset = 1'b1;
      model_reset();
      #1 check_outs();
      #9 SYS_reset = 1'b0;
   endtask

   typedef struct {
      logic btn;
      int   cycles;
      int   exp_pulses;
      int   exp_first;
      int   exp_count;
   } vec_t;

   vec_t tbl [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses, first, last, w, hold, snap_a, snap_b;
      bit found;
      divs[0] = DIV_A; divs[1] = DIV_B;
      debs[0] = DEB_A; debs[1] = DEB_B;
      tbl[0]  = '{1'b0,  4, 0, 0, 0};
      tbl[1]  = '{1'b1,  1, 0, 0, 0};
      tbl[2]  = '{1'b0,  1, 0, 0, 0};
      tbl[3]  = '{1'b1,  1, 0, 0, 0};
      tbl[4]  = '{1'b0,  1, 0, 0, 0};
      tbl[5]  = '{1'b1, 20, 1, 7, 1};
      tbl[6]  = '{1'b0, 12, 0, 0, 1};
      tbl[7]  = '{1'b1,  3, 0, 0, 1};
      tbl[8]  = '{1'b0, 12, 0, 0, 1};
      tbl[9]  = '{1'b1, 10, 1, 7, 2};
      tbl[10] = '{1'b0,  8, 0, 0, 2};

      SYS_reset = 1'b0; run_mode = 1'b0; step_btn = 1'b0; halt = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // single-step table: bounce, clean press, release, short glitch, second press
      foreach (tbl[n]) begin
         step_btn = tbl[n].btn;
         pulses = 0; first = 0;
         for (int c = 1; c <= tbl[n].cycles; c++) begin
            tick();
            if (en_a) begin
               pulses++;
               if (first == 0) first = c;
            end
         end
         chk("tbl_pulses", 32'(pulses), 32'(tbl[n].exp_pulses));
         if (tbl[n].exp_first != 0) chk("tbl_latency", 32'(first), 32'(tbl[n].exp_first));
         chk("tbl_count", cnt_a, 32'(tbl[n].exp_count));
      end

      // free-run from reset for 40 edges
      do_reset();
      run_mode = 1'b1;
      last = 0; first = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (en_a) begin
            if (first == 0) first = c;
            if (last != 0) chk("run_gap_a", 32'(c - last), 32'(DIV_A));
            last = c;
         end
      end
      chk("run_first_a", 32'(first), 32'd7);
      chk("run_count_a", cnt_a, 32'd9);
      chk("run_led_a", 32'(led_a), 32'd1);
      chk("run_count_b", cnt_b, 32'd37);

      run_mode = 1'b0;
      w = 0;
      do begin
         tick();
         w++;
      end while (en_b && w < 6);
      chk("stop_within_3", 32'(w <= 3), 32'd1);
      for (int c = 0; c < 4; c++) tick();

      // halt on the cycle a divisor strobe is due
      run_mode = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         if (mode_m[0] == 0 && ((t_m + 1 - entry_m[0]) % DIV_A) == 0) found = 1'b1;
         else tick();
      end
      chk("halt_aligned", 32'(found), 32'd1);
      halt = 1'b1;
      tick();
      chk("halt_en_a", 32'(en_a), 32'd0);
      chk("halt_state_a", 32'(st_a), 32'd2);
      chk("halt_state_b", 32'(st_b), 32'd2);
      halt = 1'b0;
      snap_a = int'(cnt_a); snap_b = int'(cnt_b);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (c % 5 == 0) run_mode = !run_mode;
         if (c % 8 == 0) step_btn = !step_btn;
         tick();
         if (en_a || en_b) pulses++;
      end
      chk("halted_pulses", 32'(pulses), 32'd0);
      chk("halted_state_a", 32'(st_a), 32'd2);
      chk("halted_count_a", cnt_a, 32'(snap_a));
      chk("halted_count_b", cnt_b, 32'(snap_b));

      // reset pulse in the middle of RUN
      do_reset();
      run_mode = 1'b1; step_btn = 1'b0;
      for (int c = 0; c < 22; c++) tick();
      do_reset();
      chk("rst_cpu_en_a", 32'(en_a), 32'd0);
      chk("rst_count_a", cnt_a, 32'd0);
      tick();
      chk("post_rst_state_a", 32'(st_a), 32'd1);
      chk("post_rst_state_b", 32'(st_b), 32'd1);

      // randomized mode changes and button activity
      do_reset();
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 79) == 0) run_mode = !run_mode;
         if (hold == 0) begin
            step_btn = !step_btn;
            hold = int'($urandom_range(1, 12));
         end else begin
            hold--;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
